// File: rtl/sonic_echo_responder.sv
// HC-SR04 responder: accepts a Trig pulse of sufficient width, waits out the burst
// delay, then drives Echo for a width proportional to the programmed distance.
module sonic_echo_responder #(
  parameter int TRIG_MIN_CYCLES = 1000,
  parameter int BURST_CYCLES    = 20000,
  parameter int CYCLES_PER_CM   = 5800,
  parameter int MIN_CM          = 2,
  parameter int MAX_CM          = 400,
  parameter int TIMEOUT_CYCLES  = 3800000,
  parameter int HOLDOFF_CYCLES  = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig,
  input  logic [9:0] distance_cm,
  output logic       echo,
  output logic       busy,
  output logic       trig_err
);

  typedef enum logic [2:0] {
    IDLE,
    TRIG_HI,
    BURST,
    ECHO,
    HOLDOFF
  } state_t;

  localparam logic [23:0] TRIG_MIN    = 24'(TRIG_MIN_CYCLES);
  localparam logic [23:0] BURST_LEN   = 24'(BURST_CYCLES);
  localparam logic [23:0] CM_CYCLES   = 24'(CYCLES_PER_CM);
  localparam logic [23:0] TIMEOUT_LEN = 24'(TIMEOUT_CYCLES);
  localparam logic [23:0] HOLDOFF_LEN = 24'(HOLDOFF_CYCLES);
  localparam logic [9:0]  MIN_D       = 10'(MIN_CM);
  localparam logic [9:0]  MAX_D       = 10'(MAX_CM);

  state_t      state_q, state_d;
  logic        sync1_q, trig_s_q, trig_d_q;
  logic [23:0] cnt_q, cnt_d;
  logic [23:0] echo_len_q, echo_len_d;
  logic        echo_q, echo_d;
  logic        busy_q, busy_d;
  logic        trig_err_q, trig_err_d;

  logic [23:0] cnt_inc;
  logic [23:0] product;
  logic        in_range;
  logic        trig_rise;

  assign cnt_inc   = cnt_q + 24'd1;
  // 1023 * CYCLES_PER_CM stays below 2^23 for the intended parameter range
  assign product   = {14'd0, distance_cm} * CM_CYCLES;
  assign in_range  = (distance_cm >= MIN_D) && (distance_cm <= MAX_D);
  assign trig_rise = trig_s_q & ~trig_d_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    echo_len_d = echo_len_q;
    echo_d     = echo_q;
    trig_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (trig_rise) begin
          state_d = TRIG_HI;
          cnt_d   = 24'd1;
        end
      end
      TRIG_HI: begin
        if (trig_s_q) begin
          if (cnt_q != 24'hFF_FFFF) cnt_d = cnt_inc;
        end else if (cnt_q >= TRIG_MIN) begin
          echo_len_d = in_range ? product : TIMEOUT_LEN;
          cnt_d      = 24'd0;
          state_d    = BURST;
        end else begin
          trig_err_d = 1'b1;
          cnt_d      = 24'd0;
          state_d    = IDLE;
        end
      end
      BURST: begin
        if (cnt_inc >= BURST_LEN) begin
          echo_d  = 1'b1;
          cnt_d   = 24'd0;
          state_d = ECHO;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ECHO: begin
        if (cnt_inc >= echo_len_q) begin
          echo_d  = 1'b0;
          cnt_d   = 24'd0;
          state_d = HOLDOFF;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HOLDOFF: begin
        if (cnt_inc >= HOLDOFF_LEN) begin
          cnt_d   = 24'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        echo_d  = 1'b0;
        cnt_d   = 24'd0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b0;
      trig_s_q   <= 1'b0;
      trig_d_q   <= 1'b0;
      cnt_q      <= 24'd0;
      echo_len_q <= 24'd0;
      echo_q     <= 1'b0;
      busy_q     <= 1'b0;
      trig_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= trig;
      trig_s_q   <= sync1_q;
      trig_d_q   <= trig_s_q;
      cnt_q      <= cnt_d;
      echo_len_q <= echo_len_d;
      echo_q     <= echo_d;
      busy_q     <= busy_d;
      trig_err_q <= trig_err_d;
    end
  end

  assign echo     = echo_q;
  assign busy     = busy_q;
  assign trig_err = trig_err_q;

endmodule
